// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request/response port between two caches, round-robin, one read in flight.
// Latency: issue strobe 2 cycles after a request pulse on an idle arbiter; read data 1 cycle after mem_response_ready.
// Backpressure: one buffered request per cache; busy_x high means a new req_ready_x pulse is dropped.
//
// Ports:
//   clock, reset                      - system clock, asynchronous active-high reset
//   req_x / req_ready_x               - request word and one-cycle valid pulse from cache x
//   busy_x                            - request slot x occupied
//   mem_request / mem_request_ready   - request word and one-cycle issue strobe to memory
//   mem_response / mem_response_ready - read data and one-cycle valid pulse from memory
//   resp_x / resp_ready_x             - read data and one-cycle valid pulse back to cache x
//   timeout_error                     - sticky flag, a read was abandoned without a response
// Request word layout: [REQ_WIDTH-1] = write flag, [23:8] = address, [7:0] = write data.
module mem_port_arbiter #(
    parameter int REQ_WIDTH  = 25,
    parameter int RESP_WIDTH = 16,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REQ_WIDTH-1:0]  req_0,
    input  logic                  req_ready_0,
    input  logic [REQ_WIDTH-1:0]  req_1,
    input  logic                  req_ready_1,
    output logic                  busy_0,
    output logic                  busy_1,
    output logic [REQ_WIDTH-1:0]  mem_request,
    output logic                  mem_request_ready,
    input  logic [RESP_WIDTH-1:0] mem_response,
    input  logic                  mem_response_ready,
    output logic [RESP_WIDTH-1:0] resp_0,
    output logic                  resp_ready_0,
    output logic [RESP_WIDTH-1:0] resp_1,
    output logic                  resp_ready_1,
    output logic                  timeout_error
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_t;

    localparam int WR_BIT = REQ_WIDTH - 1;
    // The counter starts at 0 on the first WAIT_RESP cycle, so reaching
    // TIMEOUT-1 without a response means TIMEOUT cycles have been spent waiting.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state;
    logic [REQ_WIDTH-1:0] slot_0;
    logic [REQ_WIDTH-1:0] slot_1;
    logic                 last_grant;   // cache that was issued most recently
    logic                 sel;          // owner of the request being issued / awaited
    logic                 pick;         // arbitration result for the IDLE state
    logic [CNT_WIDTH-1:0] cnt;

    // busy_x doubles as the slot-full flag. With both slots full the cache that
    // was not served last wins; otherwise the only full slot is taken.
    assign pick = (busy_0 && busy_1) ? ~last_grant : busy_1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            slot_0            <= '0;
            slot_1            <= '0;
            busy_0            <= 1'b0;
            busy_1            <= 1'b0;
            last_grant        <= 1'b1;
            sel               <= 1'b0;
            cnt               <= '0;
            mem_request       <= '0;
            mem_request_ready <= 1'b0;
            resp_0            <= '0;
            resp_ready_0      <= 1'b0;
            resp_1            <= '0;
            resp_ready_1      <= 1'b0;
            timeout_error     <= 1'b0;
        end else begin
            mem_request_ready <= 1'b0;
            resp_ready_0      <= 1'b0;
            resp_ready_1      <= 1'b0;

            // Capture into an empty slot; pulses against a full slot are dropped.
            if (req_ready_0 && !busy_0) begin
                slot_0 <= req_0;
                busy_0 <= 1'b1;
            end
            if (req_ready_1 && !busy_1) begin
                slot_1 <= req_1;
                busy_1 <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (busy_0 || busy_1) begin
                        sel               <= pick;
                        mem_request       <= pick ? slot_1 : slot_0;
                        mem_request_ready <= 1'b1;
                        state             <= ISSUE;
                    end
                end

                ISSUE: begin
                    // The slot is still marked busy during this cycle, so a
                    // capture for the same cache cannot collide with the clear.
                    if (sel) begin
                        busy_1 <= 1'b0;
                    end else begin
                        busy_0 <= 1'b0;
                    end
                    last_grant <= sel;
                    if (mem_request[WR_BIT]) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT_RESP;
                    end
                end

                WAIT_RESP: begin
                    if (mem_response_ready) begin
                        if (sel) begin
                            resp_1       <= mem_response;
                            resp_ready_1 <= 1'b1;
                        end else begin
                            resp_0       <= mem_response;
                            resp_ready_0 <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_error <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks plus randomized round-robin traffic for mem_port_arbiter.
// Timing: inputs driven 1 time unit after the rising edge; issue/response pulses logged at the falling edge.
// Reference: transaction-level model of grant order, issue timing and response routing.
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic        clock;
    logic        reset;
    logic [24:0] req_0;
    logic        req_ready_0;
    logic [24:0] req_1;
    logic        req_ready_1;
    logic        busy_0;
    logic        busy_1;
    logic [24:0] mem_request;
    logic        mem_request_ready;
    logic [15:0] mem_response;
    logic        mem_response_ready;
    logic [15:0] resp_0;
    logic        resp_ready_0;
    logic [15:0] resp_1;
    logic        resp_ready_1;
    logic        timeout_error;

    mem_port_arbiter #(
        .REQ_WIDTH (25),
        .RESP_WIDTH(16),
        .TIMEOUT   (TO),
        .CNT_WIDTH (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_0             (req_0),
        .req_ready_0       (req_ready_0),
        .req_1             (req_1),
        .req_ready_1       (req_ready_1),
        .busy_0            (busy_0),
        .busy_1            (busy_1),
        .mem_request       (mem_request),
        .mem_request_ready (mem_request_ready),
        .mem_response      (mem_response),
        .mem_response_ready(mem_response_ready),
        .resp_0            (resp_0),
        .resp_ready_0      (resp_ready_0),
        .resp_1            (resp_1),
        .resp_ready_1      (resp_ready_1),
        .timeout_error     (timeout_error)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int model_last = 1;   // cache granted most recently, per the arbitration rules

    logic [24:0] iss_q[$];
    int          iss_cyc[$];
    logic [15:0] r0_q[$];
    int          r0_cyc[$];
    logic [15:0] r1_q[$];
    int          r1_cyc[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_request_ready === 1'b1) begin
            iss_q.push_back(mem_request);
            iss_cyc.push_back(cyc);
        end
        if (resp_ready_0 === 1'b1) begin
            r0_q.push_back(resp_0);
            r0_cyc.push_back(cyc);
        end
        if (resp_ready_1 === 1'b1) begin
            r1_q.push_back(resp_1);
            r1_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_logs();
        iss_q.delete(); iss_cyc.delete();
        r0_q.delete();  r0_cyc.delete();
        r1_q.delete();  r1_cyc.delete();
    endtask

    task automatic drive_req(input logic [1:0] mask, input logic [24:0] d0, input logic [24:0] d1);
        req_0 = d0;
        req_1 = d1;
        req_ready_0 = mask[0];
        req_ready_1 = mask[1];
        tick();
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
    endtask

    task automatic drive_resp(input logic [15:0] d);
        mem_response = d;
        mem_response_ready = 1'b1;
        tick();
        mem_response_ready = 1'b0;
    endtask

    task automatic wait_issue(input int want, output bit ok);
        int n = 0;
        while (iss_q.size() < want && n < 60) begin
            tick();
            n++;
        end
        ok = (iss_q.size() >= want);
    endtask

    function automatic logic [24:0] iss_at(input int k);
        return (k < iss_q.size()) ? iss_q[k] : 25'bx;
    endfunction

    function automatic int iss_cyc_at(input int k);
        return (k < iss_cyc.size()) ? iss_cyc[k] : -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req_0 = '0; req_1 = '0; req_ready_0 = 1'b0; req_ready_1 = 1'b0;
        mem_response = '0; mem_response_ready = 1'b0;
        tick(2);
        vec_cnt++;
        if ({busy_0, busy_1, mem_request_ready, resp_ready_0, resp_ready_1, timeout_error,
             mem_request, resp_0, resp_1} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: busy=%b%b mrr=%b rr=%b%b to=%b mreq=%h r0=%h r1=%h, all required 0",
                     busy_0, busy_1, mem_request_ready, resp_ready_0, resp_ready_1, timeout_error,
                     mem_request, resp_0, resp_1);
        end
        reset = 1'b0;
        model_last = 1;
        clear_logs();
        tick(3);
        vec_cnt++;
        if (iss_q.size() != 0) begin
            err_cnt++;
            $display("FAIL reset_idle: %0d issue strobes after reset, required 0", iss_q.size());
        end
    endtask

    task automatic test_single_write();
        int c0;
        clear_logs();
        c0 = cyc;
        drive_req(2'b01, 25'h1ABCD5A, '0);
        vec_cnt++;
        if (busy_0 !== 1'b1 || mem_request_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL write_c1: busy_0=%b mrr=%b, required 1 0", busy_0, mem_request_ready);
        end
        tick();
        vec_cnt++;
        if (busy_0 !== 1'b1 || mem_request_ready !== 1'b1 || mem_request !== 25'h1ABCD5A) begin
            err_cnt++;
            $display("FAIL write_c2: busy_0=%b mrr=%b mreq=%h, required 1 1 1abcd5a",
                     busy_0, mem_request_ready, mem_request);
        end
        tick();
        vec_cnt++;
        if (busy_0 !== 1'b0 || mem_request_ready !== 1'b0 || mem_request !== 25'h1ABCD5A) begin
            err_cnt++;
            $display("FAIL write_c3: busy_0=%b mrr=%b mreq=%h, required 0 0 1abcd5a",
                     busy_0, mem_request_ready, mem_request);
        end
        tick(4);
        vec_cnt++;
        if (iss_q.size() != 1 || iss_cyc_at(0) != c0 + 2 || r0_q.size() != 0 || r1_q.size() != 0) begin
            err_cnt++;
            $display("FAIL write_log: issues=%0d at cycle %0d resp=%0d/%0d, required 1 at %0d and 0/0",
                     iss_q.size(), iss_cyc_at(0) - c0, r0_q.size(), r1_q.size(), 2);
        end
        model_last = 0;
    endtask

    task automatic test_read_round_trip();
        int c0, s;
        bit ok;
        clear_logs();
        c0 = cyc;
        drive_req(2'b10, '0, 25'h0123400);
        wait_issue(1, ok);
        vec_cnt++;
        if (!ok || iss_at(0) !== 25'h0123400 || iss_cyc_at(0) != c0 + 2) begin
            err_cnt++;
            $display("FAIL read_issue: mreq=%h at +%0d, required 0123400 at +2", iss_at(0), iss_cyc_at(0) - c0);
        end
        s = ok ? iss_cyc[0] : cyc;
        wait_until(s + 5);
        drive_resp(16'hBEEF);
        tick(3);
        vec_cnt++;
        if (r1_q.size() != 1 || r1_q[0] !== 16'hBEEF || r1_cyc[0] != s + 6) begin
            err_cnt++;
            $display("FAIL read_resp1: count=%0d data=%h cycle=+%0d, required 1 beef +6",
                     r1_q.size(), (r1_q.size() > 0) ? r1_q[0] : 16'hx, (r1_cyc.size() > 0) ? r1_cyc[0] - s : -1);
        end
        vec_cnt++;
        if (r0_q.size() != 0) begin
            err_cnt++;
            $display("FAIL read_resp0: %0d pulses on resp_ready_0, required 0", r0_q.size());
        end
        model_last = 1;
    endtask

    task automatic test_simul_writes();
        logic [24:0] a, b;
        int c0, first;
        bit ok;
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 1) begin
                // a lone cache-0 write moves the last grant to cache 0
                clear_logs();
                drive_req(2'b01, 25'h10F0F11, '0);
                tick(4);
                vec_cnt++;
                if (iss_q.size() != 1 || iss_at(0) !== 25'h10F0F11) begin
                    err_cnt++;
                    $display("FAIL simul_single: issues=%0d mreq=%h, required 1 10f0f11", iss_q.size(), iss_at(0));
                end
                model_last = 0;
            end
            a = {1'b1, 24'($urandom)};
            b = {1'b1, 24'($urandom)};
            first = (model_last == 1) ? 0 : 1;
            clear_logs();
            c0 = cyc;
            drive_req(2'b11, a, b);
            wait_issue(2, ok);
            vec_cnt++;
            if (!ok || iss_at(0) !== (first ? b : a) || iss_cyc_at(0) != c0 + 2) begin
                err_cnt++;
                $display("FAIL simul_first%0d: mreq=%h at +%0d, required %h at +2 (cache %0d)",
                         rep, iss_at(0), iss_cyc_at(0) - c0, first ? b : a, first);
            end
            vec_cnt++;
            if (!ok || iss_at(1) !== (first ? a : b) || iss_cyc_at(1) != c0 + 4) begin
                err_cnt++;
                $display("FAIL simul_second%0d: mreq=%h at +%0d, required %h at +4",
                         rep, iss_at(1), iss_cyc_at(1) - c0, first ? a : b);
            end
            model_last = 1 - first;
            tick(2);
        end
    endtask

    task automatic test_drop_busy();
        clear_logs();
        drive_req(2'b01, 25'h1111122, '0);
        drive_req(2'b01, 25'h1333344, '0);   // slot still full
        drive_req(2'b01, 25'h1555566, '0);   // ISSUE cycle, busy_0 still high
        tick(5);
        vec_cnt++;
        if (iss_q.size() != 1 || iss_at(0) !== 25'h1111122 || busy_0 !== 1'b0) begin
            err_cnt++;
            $display("FAIL drop_busy: issues=%0d first=%h busy_0=%b, required 1 1111122 0",
                     iss_q.size(), iss_at(0), busy_0);
        end
        model_last = 0;
    endtask

    task automatic test_timeout();
        int c0;
        bit ok;
        clear_logs();
        c0 = cyc;
        drive_req(2'b01, 25'h0555500, '0);
        wait_issue(1, ok);
        vec_cnt++;
        if (!ok || iss_cyc_at(0) != c0 + 2) begin
            err_cnt++;
            $display("FAIL timeout_issue: strobe at +%0d, required +2", iss_cyc_at(0) - c0);
        end
        // WAIT_RESP begins at c0+3; the flag appears TO cycles later
        wait_until(c0 + 2 + TO);
        vec_cnt++;
        if (timeout_error !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_early: timeout_error=%b at +%0d, required 0", timeout_error, TO + 2);
        end
        tick();
        vec_cnt++;
        if (timeout_error !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout_set: timeout_error=%b at +%0d, required 1", timeout_error, TO + 3);
        end
        model_last = 0;
        drive_resp(16'hDEAD);                // late, arbiter is idle
        c0 = cyc;
        drive_req(2'b10, '0, 25'h1777788);
        tick();
        drive_resp(16'hCAFE);                // during the write issue
        tick(4);
        vec_cnt++;
        if (iss_q.size() != 2 || iss_at(1) !== 25'h1777788 || iss_cyc_at(1) != c0 + 2) begin
            err_cnt++;
            $display("FAIL timeout_write: issues=%0d mreq=%h at +%0d, required 2 1777788 +2",
                     iss_q.size(), iss_at(1), iss_cyc_at(1) - c0);
        end
        vec_cnt++;
        if (r0_q.size() != 0 || r1_q.size() != 0 || timeout_error !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout_late_resp: resp pulses=%0d/%0d timeout_error=%b, required 0/0 1",
                     r0_q.size(), r1_q.size(), timeout_error);
        end
        model_last = 1;
    endtask

    task automatic test_reset_mid();
        int c0;
        bit ok;
        logic [24:0] a, b;
        clear_logs();
        c0 = cyc;
        drive_req(2'b10, '0, 25'h0999900);
        wait_issue(1, ok);
        wait_until(c0 + 3);
        drive_req(2'b10, '0, 25'h1AAAABB);
        vec_cnt++;
        if (busy_1 !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_mid_slot: busy_1=%b, required 1", busy_1);
        end
        #2 reset = 1'b1;
        #1;
        vec_cnt++;
        if ({busy_0, busy_1, mem_request_ready, resp_ready_0, resp_ready_1, timeout_error,
             mem_request, resp_0, resp_1} !== '0) begin
            err_cnt++;
            $display("FAIL rst_mid_outputs: busy=%b%b mrr=%b to=%b mreq=%h, all required 0",
                     busy_0, busy_1, mem_request_ready, timeout_error, mem_request);
        end
        tick(2);
        reset = 1'b0;
        model_last = 1;
        clear_logs();
        tick(2);
        drive_resp(16'h1234);                // orphaned response for the discarded read
        tick(8);
        vec_cnt++;
        if (iss_q.size() != 0 || r0_q.size() != 0 || r1_q.size() != 0 || busy_1 !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_quiet: issues=%0d resp=%0d/%0d busy_1=%b, required 0 0/0 0",
                     iss_q.size(), r0_q.size(), r1_q.size(), busy_1);
        end
        // fresh tie after reset goes to cache 0
        a = {1'b1, 24'($urandom)};
        b = {1'b1, 24'($urandom)};
        drive_req(2'b11, a, b);
        wait_issue(2, ok);
        vec_cnt++;
        if (!ok || iss_at(0) !== a || iss_at(1) !== b) begin
            err_cnt++;
            $display("FAIL rst_mid_tie: order %h,%h, required %h,%h", iss_at(0), iss_at(1), a, b);
        end
        model_last = 1;
        tick(2);
    endtask

    task automatic test_random();
        logic [1:0]  mask;
        logic [24:0] d0, d1, want;
        logic [15:0] rd;
        int          order[$];
        logic [15:0] e0_d[$], e1_d[$];
        int          e0_c[$], e1_c[$];
        int          c0, s, exp_cyc, who, dly;
        bit          ok;
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(1, 3));
            d0 = 25'($urandom);
            d1 = 25'($urandom);
            order.delete();
            e0_d.delete(); e1_d.delete(); e0_c.delete(); e1_c.delete();
            if (mask == 2'b11) begin
                order.push_back(model_last == 1 ? 0 : 1);
                order.push_back(model_last == 1 ? 1 : 0);
            end else begin
                order.push_back(mask[1] ? 1 : 0);
            end
            clear_logs();
            c0 = cyc;
            drive_req(mask, d0, d1);
            // second pulse against occupied slots must vanish
            if ($urandom_range(0, 1) == 1) drive_req(mask, ~d0, ~d1);
            exp_cyc = c0 + 2;
            for (int k = 0; k < order.size(); k++) begin
                wait_issue(k + 1, ok);
                who  = order[k];
                want = who ? d1 : d0;
                vec_cnt++;
                if (!ok || iss_at(k) !== want || iss_cyc_at(k) != exp_cyc) begin
                    err_cnt++;
                    $display("FAIL rand_issue it%0d k%0d: mreq=%h at %0d, required %h at %0d",
                             it, k, iss_at(k), iss_cyc_at(k), want, exp_cyc);
                end
                s = ok ? iss_cyc[k] : cyc;
                model_last = who;
                if (want[24]) begin
                    exp_cyc = s + 2;
                end else begin
                    dly = $urandom_range(1, TO);
                    rd  = 16'($urandom);
                    wait_until(s + dly);
                    drive_resp(rd);
                    if (who == 1) begin
                        e1_d.push_back(rd); e1_c.push_back(s + dly + 1);
                    end else begin
                        e0_d.push_back(rd); e0_c.push_back(s + dly + 1);
                    end
                    exp_cyc = s + dly + 2;
                end
            end
            tick(4);
            vec_cnt++;
            if (iss_q.size() != order.size() || r0_q.size() != e0_d.size() || r1_q.size() != e1_d.size()) begin
                err_cnt++;
                $display("FAIL rand_counts it%0d: issues=%0d resp=%0d/%0d, required %0d %0d/%0d",
                         it, iss_q.size(), r0_q.size(), r1_q.size(), order.size(), e0_d.size(), e1_d.size());
            end else begin
                for (int k = 0; k < e0_d.size(); k++) begin
                    vec_cnt++;
                    if (r0_q[k] !== e0_d[k] || r0_cyc[k] != e0_c[k]) begin
                        err_cnt++;
                        $display("FAIL rand_resp0 it%0d: %h at %0d, required %h at %0d",
                                 it, r0_q[k], r0_cyc[k], e0_d[k], e0_c[k]);
                    end
                end
                for (int k = 0; k < e1_d.size(); k++) begin
                    vec_cnt++;
                    if (r1_q[k] !== e1_d[k] || r1_cyc[k] != e1_c[k]) begin
                        err_cnt++;
                        $display("FAIL rand_resp1 it%0d: %h at %0d, required %h at %0d",
                                 it, r1_q[k], r1_cyc[k], e1_d[k], e1_c[k]);
                    end
                end
            end
            vec_cnt++;
            if (timeout_error !== 1'b0 || busy_0 !== 1'b0 || busy_1 !== 1'b0) begin
                err_cnt++;
                $display("FAIL rand_idle it%0d: timeout_error=%b busy=%b%b, required 0 00",
                         it, timeout_error, busy_0, busy_1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_round_trip();
        test_simul_writes();
        test_drop_busy();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
